// File: rtl/hist_bin_accum.sv
// -----------------------------------------------------------------------------
// hist_bin_accum
//   Histogram bin writer. Each accepted 8-bit pixel increments the bin whose
//   index equals its intensity. All 256 bins are exposed on one flat bus for a
//   downstream 256:1 bin-select mux. A frame runs: start, a 256-cycle clear
//   sweep, accumulation until the pixel flagged last, then a one-cycle done.
//
//   Optional build macro: HIST_BIN_SAT_EN
//     defined   -> bins saturate at all-ones, sat_any flags a hit on a full bin
//     undefined -> bins wrap modulo 2^WIDTH, sat_any stays 0
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a new frame (honoured in IDLE or DONE only)
//   pix_valid  in   pix_data / pix_last are valid
//   pix_ready  out  block accepts a pixel this cycle (registered)
//   pix_data   in   pixel intensity = bin index
//   pix_last   in   final pixel of the frame, qualified by pix_valid
//   bins_flat  out  bin k at bits [k*WIDTH +: WIDTH]
//   pix_count  out  pixels accepted this frame, saturating
//   busy       out  high during CLEAR and ACCUM
//   done       out  one-cycle pulse on frame completion
//   sat_any    out  sticky flag: some bin saturated this frame
// -----------------------------------------------------------------------------
module hist_bin_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [7:0]             pix_data,
    input  logic                   pix_last,
    output logic [256*WIDTH-1:0]   bins_flat,
    output logic [CNT_W-1:0]       pix_count,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_any
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic [7:0]       clr_idx_q;
    logic [WIDTH-1:0] bins_q [256];
    logic [CNT_W-1:0] pix_count_q;
    logic             pix_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             sat_any_q;

    logic             accept_s;
    logic [WIDTH-1:0] bin_cur_s;
    logic             bin_at_max_s;
    logic [WIDTH-1:0] bin_d;
    logic [CNT_W-1:0] pix_count_d;

    // Handshake and next values for the addressed bin and the pixel counter.
    // The bin is read straight from its register, so back-to-back hits on the
    // same index see the previous increment without any forwarding.
    always_comb begin
        accept_s  = (state_q == S_ACCUM) && pix_valid && pix_ready_q;
        bin_cur_s = bins_q[pix_data];
`ifdef HIST_BIN_SAT_EN
        bin_at_max_s = (bin_cur_s == BIN_MAX);
        if (bin_at_max_s) begin
            bin_d = bin_cur_s;
        end else begin
            bin_d = bin_cur_s + BIN_ONE;
        end
`else
        bin_at_max_s = 1'b0;
        bin_d        = bin_cur_s + BIN_ONE;
`endif
        if (pix_count_q == CNT_MAX) begin
            pix_count_d = pix_count_q;
        end else begin
            pix_count_d = pix_count_q + CNT_ONE;
        end
    end

    // Bin storage: the clear sweep zeroes one bin per cycle, accumulation
    // writes the addressed bin; the two never overlap in time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) begin
                bins_q[k] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            bins_q[clr_idx_q] <= '0;
        end else if (accept_s) begin
            bins_q[pix_data] <= bin_d;
        end
    end

    // Frame control FSM with its registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clr_idx_q   <= 8'd0;
            pix_count_q <= '0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_any_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_CLEAR;
                        clr_idx_q   <= 8'd0;
                        pix_count_q <= '0;
                        sat_any_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Index wraps back to 0 naturally after bin 255.
                    clr_idx_q <= clr_idx_q + 8'd1;
                    if (clr_idx_q == 8'd255) begin
                        state_q     <= S_ACCUM;
                        pix_ready_q <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (accept_s) begin
                        pix_count_q <= pix_count_d;
                        if (bin_at_max_s) begin
                            sat_any_q <= 1'b1;
                        end
                        if (pix_last) begin
                            state_q     <= S_DONE;
                            pix_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_CLEAR;
                        clr_idx_q   <= 8'd0;
                        pix_count_q <= '0;
                        sat_any_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < 256; k++) begin : g_flat
        assign bins_flat[k*WIDTH +: WIDTH] = bins_q[k];
    end

    assign pix_ready = pix_ready_q;
    assign pix_count = pix_count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_any   = sat_any_q;

endmodule

// File: tb/tb_hist_bin_accum.sv
module tb_hist_bin_accum;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    pix_data = 8'd0;
    logic          pix_last = 1'b0;
    logic [2047:0] bins_flat;
    logic [15:0]   pix_count;
    logic          busy;
    logic          done;
    logic          sat_any;

    int total = 0;
    int bad   = 0;

    hist_bin_accum #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .bins_flat (bins_flat),
        .pix_count (pix_count),
        .busy      (busy),
        .done      (done),
        .sat_any   (sat_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bin_at(input int k);
        return int'(bins_flat[k*8 +: 8]);
    endfunction

    function automatic int nonzero_bins();
        int n = 0;
        for (int k = 0; k < 256; k++) begin
            if (bins_flat[k*8 +: 8] != 8'd0) n++;
        end
        return n;
    endfunction

    task automatic send(input logic [7:0] d, input logic v, input logic l);
        pix_data  = d;
        pix_valid = v;
        pix_last  = l;
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Called in the first CLEAR cycle; returns once pix_ready rises.
    task automatic wait_clear(input string tag);
        int n = 0;
        int busy_bad = 0;
        while (pix_ready !== 1'b1 && n < 400) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            n++;
        end
        check({tag, "_clear_cycles"}, n, 256);
        check({tag, "_clear_busy"}, busy_bad, 0);
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        check({tag, "_ready_after_start"}, int'(pix_ready), 0);
        wait_clear(tag);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ready", int'(pix_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(pix_count), 0);
        check("rst_sat", int'(sat_any), 0);
        check("rst_bins", nonzero_bins(), 0);
        reset = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);

        // Preload frame: bin 7 = 3
        start_frame("f1");
        send(8'd7, 1'b1, 1'b0);
        send(8'd7, 1'b1, 1'b0);
        send(8'd7, 1'b1, 1'b1);
        check("f1_done", int'(done), 1);
        check("f1_bin7", bin_at(7), 3);
        check("f1_count", int'(pix_count), 3);
        tick();
        check("f1_done_drop", int'(done), 0);
        tick();
        check("f1_hold_bin7", bin_at(7), 3);

        // Single frame 0,255,128,128 after a clear that wipes bin 7
        start_frame("f2");
        check("f2_bin7_cleared", bin_at(7), 0);
        check("f2_ready_257", int'(pix_ready), 1);
        send(8'd0, 1'b1, 1'b0);
        send(8'd255, 1'b1, 1'b0);
        send(8'd128, 1'b1, 1'b0);
        check("f2_no_early_done", int'(done), 0);
        check("f2_bin128_mid", bin_at(128), 1);
        send(8'd128, 1'b1, 1'b1);
        check("f2_done", int'(done), 1);
        check("f2_ready_low", int'(pix_ready), 0);
        check("f2_bin0", bin_at(0), 1);
        check("f2_bin255", bin_at(255), 1);
        check("f2_bin128", bin_at(128), 2);
        check("f2_others", nonzero_bins(), 3);
        check("f2_count", int'(pix_count), 4);
        tick();
        check("f2_done_once", int'(done), 0);
        check("f2_idle_busy", int'(busy), 0);

        // 10 beats of 42 with valid toggling; stray last/start in gaps ignored
        start_frame("f3");
        for (int i = 0; i < 19; i++) begin
            if (i % 2 == 0) begin
                send(8'd42, 1'b1, (i == 18));
            end else begin
                start = (i == 3);
                send(8'd43, 1'b0, (i == 1));
                start = 1'b0;
            end
        end
        check("f3_done", int'(done), 1);
        check("f3_bin42", bin_at(42), 10);
        check("f3_bin43", bin_at(43), 0);
        check("f3_count", int'(pix_count), 10);

        // Overflow: 300 hits on bin 5, then start on the done cycle
        tick();
        start_frame("f4");
        for (int i = 0; i < 300; i++) begin
            send(8'd5, 1'b1, (i == 299));
        end
        check("f4_done", int'(done), 1);
        check("f4_count", int'(pix_count), 300);
`ifdef HIST_BIN_SAT_EN
        check("f4_bin5", bin_at(5), 255);
        check("f4_sat", int'(sat_any), 1);
`else
        check("f4_bin5", bin_at(5), 44);
        check("f4_sat", int'(sat_any), 0);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f5_done_drop", int'(done), 0);
        check("f5_busy", int'(busy), 1);
        check("f5_ready", int'(pix_ready), 0);
        check("f5_sat_clr", int'(sat_any), 0);
        check("f5_count_clr", int'(pix_count), 0);
`ifdef HIST_BIN_SAT_EN
        check("f5_unswept_bin5", bin_at(5), 255);
`else
        check("f5_unswept_bin5", bin_at(5), 44);
`endif
        wait_clear("f5");
        check("f5_bin5_cleared", bin_at(5), 0);

        // Reset mid-ACCUM takes effect within the same cycle
        send(8'd9, 1'b1, 1'b0);
        send(8'd9, 1'b1, 1'b0);
        check("f5_bin9", bin_at(9), 2);
        reset = 1'b1;
        #1;
        check("mr_bins", nonzero_bins(), 0);
        check("mr_count", int'(pix_count), 0);
        check("mr_ready", int'(pix_ready), 0);
        check("mr_busy", int'(busy), 0);
        #1;
        reset = 1'b0;
        tick();
        tick();
        check("mr_idle_busy", int'(busy), 0);
        check("mr_idle_ready", int'(pix_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hist_bin_accum.md
Name: hist_bin_accum

Overview:
Histogram bin writer. Consumes a stream of 8-bit pixel intensities and increments the matching one of 256 bin counters. Exposes all bins as one flat bus that feeds the 256:1 bin-select mux, which reads individual bins out.
A frame is: start, clear sweep, accumulate until the last pixel, done.

Parameters:
WIDTH, 8, bin counter width in bits; also the per-bin slice width on bins_flat.
CNT_W, 16, width of the accepted-pixel counter pix_count.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin new frame; honoured only in IDLE or DONE
pix_valid  in  1  pix_data valid
pix_ready  out  1  block can accept a pixel (registered)
pix_data  in  8  pixel intensity = bin index 0..255
pix_last  in  1  qualifies the final pixel of the frame; sampled with pix_valid
bins_flat  out  256*WIDTH  bin k at bits [k*WIDTH +: WIDTH]
pix_count  out  CNT_W  pixels accepted this frame, saturating at all-ones
busy  out  1  high in CLEAR and ACCUM
done  out  1  one-cycle pulse on frame completion
sat_any  out  1  sticky: some bin saturated this frame

Behaviour:
- Reset, asynchronous: state=IDLE, all bins=0, pix_count=0, pix_ready=0, busy=0, done=0, sat_any=0, clr_idx=0.
- States: IDLE, CLEAR, ACCUM, DONE.
- IDLE: start=1 -> CLEAR; clr_idx=0, pix_count=0, sat_any=0.
- CLEAR:
  - Zeroes bin[clr_idx] each cycle; clr_idx increments.
  - At clr_idx=255, that bin is zeroed -> ACCUM. Total 256 cycles. clr_idx wraps to 0.
  - pix_ready=0. start is ignored.
- ACCUM:
  - pix_ready=1.
  - Accept on pix_valid & pix_ready: bin[pix_data] += 1, pix_count += 1 (saturating).
  - Updated value appears on bins_flat the cycle after acceptance.
  - Back-to-back hits on the same bin accumulate correctly, one increment per accepted beat, no stall.
  - Accept with pix_last=1 -> DONE; pix_ready deasserts from the next cycle. That pixel is counted.
  - pix_last without pix_valid is ignored. start is ignored.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - If start=1 during DONE -> CLEAR directly; done still pulses this cycle.
- Bins hold their values in IDLE/DONE until the next CLEAR sweep; the downstream mux reads them there.
- Bins not yet reached by the CLEAR sweep keep their old values until swept.
- Reset mid-CLEAR or mid-ACCUM: immediate return to the reset state; partial frame discarded.
- Bin arithmetic: unsigned WIDTH bits; overflow handling per the optional feature.
- pix_count saturates at 2^CNT_W-1 regardless of the macro.

Optional Feature:
HIST_BIN_SAT_EN
- Defined:
  - Bins saturate at 2^WIDTH-1; further hits leave the bin unchanged.
  - sat_any sets the cycle after any accepted hit on a bin already at max. Stays set until the next start->CLEAR.
- Undefined:
  - Bins wrap modulo 2^WIDTH (255+1 -> 0 at WIDTH=8).
  - sat_any is tied to 0.

Test Plan:
- Reset then idle: assert reset mid-ACCUM -> all bins 0, pix_count 0, pix_ready 0, state IDLE in the same cycle as reset.
- Clear timing: preload via a frame with bin[7]=3. Pulse start -> busy=1, pix_ready stays 0 for exactly 256 cycles. bin[7]=0 at the end. pix_ready=1 on cycle 257.
- Single frame: pixels 0, 255, 128, 128 (last on the 4th) -> bin0=1, bin255=1, bin128=2, others 0, pix_count=4. done pulses once, 1 cycle after the last accept.
- Back-to-back with valid gaps: 10 beats of intensity 42, valid toggling 1,0,1... -> bin42=10, pix_count=10, no lost or double counts.
- Overflow, WIDTH=8, 300 hits on bin 5: with HIST_BIN_SAT_EN -> bin5=255, sat_any=1. Without it -> bin5=44, sat_any=0.
- Start in DONE: start asserted on the done cycle -> done=1 that cycle, next cycle busy=1 in CLEAR. start asserted during ACCUM -> no effect.
